incline_led_monitor: RTL and testbench

- Parametrised successor to the single-sample incline LED display.
- Sits downstream of inert_intf: consumes its vld/incline stream and keeps a moving average over 2^LOG_DEPTH samples plus min/max peak hold.
- Drives an NLED-wide LED bank in one of four selectable modes.
- Adds a stale-data watchdog that blinks the LEDs when the sensor stops producing samples.

---
 rtl/incline_mon_pkg.sv | 23 ++
 rtl/incline_avg.sv | 70 +++++++
 rtl/incline_led_monitor.sv | 173 +++++++++++++++++
 tb/tb_incline_led_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/incline_mon_pkg.sv
// Shared types and helpers for the incline LED monitor.
package incline_mon_pkg;

    typedef enum logic [1:0] {
        RAW = 2'd0,
        AVG = 2'd1,
        BAR = 2'd2,
        P2P = 2'd3
    } led_mode_t;

    localparam int unsigned ThermMaxW = 64;

    // Thermometer code: the n least-significant bits set; callers truncate to their width.
    function automatic logic [ThermMaxW-1:0] thermo(input int unsigned n);
        logic [ThermMaxW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < ThermMaxW; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/incline_avg.sv
// Moving average over 2^LOG_DEPTH incline samples using a circular buffer and running sum.
module incline_avg #(
    parameter int unsigned W         = 13,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vld_i,
    input  logic signed [W-1:0] incline_i,
    output logic signed [W-1:0] avg_o,
    output logic                avg_vld_o
);

    localparam int unsigned Depth = 1 << LOG_DEPTH;
    localparam int unsigned SumW  = W + LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FillFull = (LOG_DEPTH + 1)'(Depth);

    logic signed [W-1:0]    samp_q [Depth];
    logic [LOG_DEPTH-1:0]   wptr_q, wptr_d;
    logic [LOG_DEPTH:0]     fill_q, fill_d;
    logic signed [SumW-1:0] sum_q, sum_d;
    logic signed [W-1:0]    avg_q, avg_d;
    logic                   avg_vld_q, avg_vld_d;

    // Next-state: swap the oldest sample out of the sum and publish the new average.
    always_comb begin
        sum_d     = sum_q;
        wptr_d    = wptr_q;
        fill_d    = fill_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        if (vld_i) begin
            sum_d  = sum_q + SumW'(incline_i) - SumW'(samp_q[wptr_q]);
            wptr_d = wptr_q + LOG_DEPTH'(1);
            if (fill_q != FillFull) begin
                fill_d = fill_q + (LOG_DEPTH + 1)'(1);
            end
            avg_d     = W'(sum_d >>> LOG_DEPTH);
            // Average tracks the partial sum, but is only flagged valid once the window is full.
            avg_vld_d = (fill_d == FillFull);
        end
    end

    // State registers and sample buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                samp_q[i] <= '0;
            end
            wptr_q    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
        end else begin
            if (vld_i) begin
                samp_q[wptr_q] <= incline_i;
            end
            wptr_q    <= wptr_d;
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
        end
    end

    assign avg_o     = avg_q;
    assign avg_vld_o = avg_vld_q;

endmodule

// File: rtl/incline_led_monitor.sv
// Incline monitor: moving average, peak hold, four-mode LED bank and stale-data watchdog.
module incline_led_monitor
    import incline_mon_pkg::*;
#(
    parameter int unsigned W         = 13,
    parameter int unsigned LOG_DEPTH = 3,
    parameter int unsigned NLED      = 8,
    parameter int unsigned BAR_SHIFT = 5,
    parameter int unsigned TIMEOUT   = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld,
    input  logic signed [W-1:0] incline,
    input  logic [1:0]          mode,
    input  logic                clr_pk,
    output logic signed [W-1:0] avg,
    output logic                avg_vld,
    output logic                stale,
    output logic [NLED-1:0]     LED
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic signed [W-1:0] avg_w;
    logic                avg_vld_w;

    incline_avg #(
        .W         (W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_avg (
        .clk_i     (clk),
        .rst_i     (rst),
        .vld_i     (vld),
        .incline_i (incline),
        .avg_o     (avg_w),
        .avg_vld_o (avg_vld_w)
    );

    led_mode_t           mode_e;
    logic signed [W-1:0] min_q, min_d, max_q, max_d;
    logic                pk_valid_q, pk_valid_d;
    logic [NLED-1:0]     led_q, led_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                stale_q, stale_d;
    logic                blink_q, blink_d;

    logic [W:0]          pk_diff;
    logic [NLED-1:0]     led_p2p;
    logic [W-1:0]        avg_abs;
    logic [W-1:0]        bar_n;
    logic [W-1:0]        bar_cnt;
    logic [NLED-1:0]     led_bar;
    logic                upd;
    logic                unused_diff_lsb;

    assign mode_e = led_mode_t'(mode);

    // Peak hold: a clear is applied first so a coincident sample reloads the window.
    always_comb begin
        min_d      = min_q;
        max_d      = max_q;
        pk_valid_d = pk_valid_q;
        if (clr_pk) begin
            pk_valid_d = 1'b0;
            min_d      = '0;
            max_d      = '0;
        end
        if (vld) begin
            if (!pk_valid_d) begin
                min_d = incline;
                max_d = incline;
            end else begin
                if (incline < min_d) min_d = incline;
                if (incline > max_d) max_d = incline;
            end
            pk_valid_d = 1'b1;
        end
    end

    // Derived LED patterns for P2P (peak-to-peak span) and BAR (thermometer of |avg|).
    always_comb begin
        pk_diff = (W + 1)'(max_d) - (W + 1)'(min_d);
        led_p2p = (|pk_diff[W:NLED+1]) ? '1 : pk_diff[NLED:1];
        if (avg_w[W-1] && !(|avg_w[W-2:0])) begin
            avg_abs = {1'b0, {(W-1){1'b1}}};
        end else if (avg_w[W-1]) begin
            avg_abs = -avg_w;
        end else begin
            avg_abs = avg_w;
        end
        bar_n   = avg_abs >> BAR_SHIFT;
        bar_cnt = (bar_n > W'(NLED)) ? W'(NLED) : bar_n;
        led_bar = NLED'(thermo(32'(bar_cnt)));
    end

    assign unused_diff_lsb = pk_diff[0];

    // LED register: each mode updates on its own event and holds otherwise.
    always_comb begin
        led_d = led_q;
        upd   = 1'b0;
        unique case (mode_e)
            RAW: if (vld) begin
                upd   = 1'b1;
                led_d = incline[NLED:1];
            end
            AVG: if (avg_vld_w) begin
                upd   = 1'b1;
                led_d = avg_w[NLED:1];
            end
            BAR: if (avg_vld_w) begin
                upd   = 1'b1;
                led_d = led_bar;
            end
            P2P: if (vld && pk_valid_d) begin
                upd   = 1'b1;
                led_d = led_p2p;
            end
            default: ;
        endcase
        // A sample ending a stale period blanks the LEDs unless it refreshes them.
        if (vld && stale_q && !upd) begin
            led_d = '0;
        end
    end

    // Watchdog: count idle cycles, flag stale and toggle blink every TIMEOUT cycles.
    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale_q;
        blink_d = blink_q;
        if (vld) begin
            cnt_d   = '0;
            stale_d = 1'b0;
            blink_d = 1'b0;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            stale_d = 1'b1;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // State registers for peak hold, LED and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q      <= '0;
            max_q      <= '0;
            pk_valid_q <= 1'b0;
            led_q      <= '0;
            cnt_q      <= '0;
            stale_q    <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            pk_valid_q <= pk_valid_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            blink_q    <= blink_d;
        end
    end

    assign avg     = avg_w;
    assign avg_vld = avg_vld_w;
    assign stale   = stale_q;
    assign LED     = stale_q ? {NLED{blink_q}} : led_q;

endmodule

// File: tb/tb_incline_led_monitor.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic against a model.
module tb_incline_led_monitor;

    localparam int W    = 13;
    localparam int LD   = 3;
    localparam int NLED = 8;
    localparam int BS   = 5;
    localparam int TO   = 16;

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                vld     = 1'b0;
    logic                clr_pk  = 1'b0;
    logic signed [W-1:0] incline = '0;
    logic [1:0]          mode    = 2'd0;
    logic signed [W-1:0] avg;
    logic                avg_vld;
    logic                stale;
    logic [NLED-1:0]     led;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    incline_led_monitor #(
        .W         (W),
        .LOG_DEPTH (LD),
        .NLED      (NLED),
        .BAR_SHIFT (BS),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .incline (incline),
        .mode    (mode),
        .clr_pk  (clr_pk),
        .avg     (avg),
        .avg_vld (avg_vld),
        .stale   (stale),
        .LED     (led)
    );

    // Reference model state: outputs expected after the most recent clock edge.
    int hist[$];
    int nsamp;
    int e_avg;
    bit e_avg_vld;
    int mn, mx;
    bit pkv;
    int e_led;
    int idle;
    bit e_stale, e_blink;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int s, input int d);
        int r;
        r = s % d;
        if (r < 0) r += d;
        return (s - r) / d;
    endfunction

    task automatic model_reset();
        hist.delete();
        nsamp     = 0;
        e_avg     = 0;
        e_avg_vld = 0;
        mn        = 0;
        mx        = 0;
        pkv       = 0;
        e_led     = 0;
        idle      = 0;
        e_stale   = 0;
        e_blink   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently presented.
    task automatic model_step();
        int  inc, s, n_avg, a, n, d, new_led;
        bit  n_avg_vld, ev;
        inc       = int'(incline);
        n_avg     = e_avg;
        n_avg_vld = 0;
        if (vld) begin
            hist.push_back(inc);
            if (hist.size() > (1 << LD)) void'(hist.pop_front());
            if (nsamp < (1 << LD)) nsamp++;
            s = 0;
            foreach (hist[i]) s += hist[i];
            n_avg     = floordiv(s, 1 << LD);
            n_avg_vld = (nsamp == (1 << LD));
            if (clr_pk || !pkv) begin
                mn = inc;
                mx = inc;
            end else begin
                if (inc < mn) mn = inc;
                if (inc > mx) mx = inc;
            end
            pkv = 1;
        end else if (clr_pk) begin
            pkv = 0;
            mn  = 0;
            mx  = 0;
        end
        ev      = 0;
        new_led = e_led;
        case (mode)
            2'd0: if (vld) begin
                ev = 1; new_led = ((inc & 8191) >> 1) & 255;
            end
            2'd1: if (e_avg_vld) begin
                ev = 1; new_led = ((e_avg & 8191) >> 1) & 255;
            end
            2'd2: if (e_avg_vld) begin
                a = (e_avg < 0) ? -e_avg : e_avg;
                if (a > 4095) a = 4095;
                n = a >> BS;
                if (n > NLED) n = NLED;
                ev = 1; new_led = (1 << n) - 1;
            end
            default: if (vld) begin
                d = mx - mn;
                ev = 1; new_led = ((d >> 1) > 255) ? 255 : (d >> 1);
            end
        endcase
        if (vld && e_stale && !ev) new_led = 0;
        e_led = new_led;
        if (vld) begin
            idle    = 0;
            e_stale = 0;
            e_blink = 0;
        end else begin
            idle++;
            if (idle % TO == 0) begin
                e_stale = 1;
                e_blink = ~e_blink;
            end
        end
        e_avg     = n_avg;
        e_avg_vld = n_avg_vld;
    endtask

    // Compare process: check every cycle on the falling edge, then step the model.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("rst_avg", int'(avg), 0);
            chk("rst_avg_vld", int'(avg_vld), 0);
            chk("rst_stale", int'(stale), 0);
            chk("rst_led", int'(led), 0);
        end else begin
            chk("avg", int'(avg), e_avg);
            chk("avg_vld", int'(avg_vld), int'(e_avg_vld));
            chk("stale", int'(stale), int'(e_stale));
            chk("led", int'(led), e_stale ? (e_blink ? 255 : 0) : e_led);
            model_step();
        end
    end

    task automatic cyc(input bit v, input int inc, input bit c);
        vld     = v;
        incline = W'(inc);
        clr_pk  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        vld    = 0;
        clr_pk = 0;
        rst    = 1;
        #1;
        chk("async_rst_avg", int'(avg), 0);
        chk("async_rst_avg_vld", int'(avg_vld), 0);
        chk("async_rst_stale", int'(stale), 0);
        chk("async_rst_led", int'(led), 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Fill the window with +40.
        mode = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 40, 0);
            if (i < 8) chk("avg_vld_early", int'(avg_vld), 0);
        end
        chk("fill_avg_vld", int'(avg_vld), 1);
        chk("fill_avg", int'(avg), 40);

        // Step down to -88.
        cyc(1, -88, 0);
        chk("step_avg", int'(avg), 24);
        repeat (7) cyc(1, -88, 0);
        chk("settle_avg", int'(avg), -88);

        // Bar graph.
        mode = 2'd2;
        repeat (8) cyc(1, 100, 0);
        cyc(0, 0, 0);
        chk("bar_100", int'(led), 8'h07);
        repeat (8) cyc(1, -4096, 0);
        cyc(0, 0, 0);
        chk("bar_neg_full", int'(led), 8'hFF);

        // Peak-to-peak.
        mode = 2'd3;
        cyc(0, 0, 1);
        cyc(1, 10, 0);
        cyc(1, -30, 0);
        cyc(1, 200, 0);
        chk("p2p_230", int'(led), 115);
        cyc(1, 5, 1);
        chk("p2p_clr_vld", int'(led), 0);

        // Watchdog.
        mode = 2'd0;
        idle_n(15);
        chk("stale_not_yet", int'(stale), 0);
        idle_n(1);
        chk("stale_set", int'(stale), 1);
        chk("stale_blink_on", int'(led), 8'hFF);
        idle_n(16);
        chk("stale_hold", int'(stale), 1);
        chk("stale_blink_off", int'(led), 8'h00);
        cyc(1, 6, 0);
        chk("stale_clear", int'(stale), 0);
        chk("stale_raw_led", int'(led), 3);

        // Reset mid-window discards history.
        repeat (5) cyc(1, 77, 0);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1, -3, 0);
            if (i < 8) chk("post_rst_avg_vld_early", int'(avg_vld), 0);
        end
        chk("post_rst_avg_vld", int'(avg_vld), 1);
        chk("post_rst_avg", int'(avg), -3);

        // Randomized traffic.
        for (int it = 0; it < 4000; it++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 20) mode = 2'($urandom_range(0, 3));
            if (r < 4) begin
                do_reset();
            end else if (r < 14) begin
                idle_n(int'($urandom_range(10, 40)));
            end else begin
                cyc(($urandom_range(0, 99) < 60),
                    int'($urandom_range(0, 8191)) - 4096,
                    ($urandom_range(0, 99) < 5));
            end
        end
        cyc(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
